// File: rtl/tone_pkg.sv
// tone_pkg: shared types and constants for the tone detector.
//   NUM_NOTES   - number of keys recognised (C4..B4).
//   note_t      - 4-bit note index, 0 = C4 .. 11 = B4.
//   state_t     - detector FSM states.
//   NOTE_PERIOD - tone period of each key in 100 MHz CLK cycles.
//   note_onehot - note index to one-hot key vector.
package tone_pkg;

  localparam int NUM_NOTES = 12;

  typedef logic [3:0] note_t;

  typedef enum logic [1:0] {
    SILENT  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  // Same table the keyboard tone generator divides by, so a loopback
  // tone lands in the centre of its window.
  localparam int unsigned NOTE_PERIOD [NUM_NOTES] = '{
    382225, 360772, 340524, 321412, 303372, 286346,
    270275, 255105, 240788, 227273, 214517, 202477
  };

  function automatic logic [NUM_NOTES-1:0] note_onehot(input note_t idx);
    logic [NUM_NOTES-1:0] one;
    one = {{(NUM_NOTES-1){1'b0}}, 1'b1};
    return one << idx;
  endfunction

endpackage

// File: rtl/period_classifier.sv
// period_classifier: maps a measured period to the key whose window holds it.
//   period (in)  PERIOD_W  measured rising-edge-to-rising-edge period.
//   hit    (out) 1         some key window contains period.
//   index  (out) 4         matching key index; 0 when hit is low.
// Window for key k is NOTE_PERIOD[k] +/- (NOTE_PERIOD[k] >> TOL_SHIFT).
// PERIOD_SHIFT scales the whole table down (0 = native 100 MHz periods),
// which lets the same detector follow a proportionally faster tone.
module period_classifier
  import tone_pkg::*;
#(
  parameter int PERIOD_W     = 20,
  parameter int TOL_SHIFT    = 6,
  parameter int PERIOD_SHIFT = 0
) (
  input  logic [PERIOD_W-1:0] period,
  output logic                hit,
  output note_t               index
);

  logic [NUM_NOTES-1:0] match;

  // Range compare one bit wider than the counter, so T + tol never wraps.
  for (genvar gi = 0; gi < NUM_NOTES; gi++) begin : g_win
    localparam int unsigned TARGET = NOTE_PERIOD[gi] >> PERIOD_SHIFT;
    localparam int unsigned TOL    = TARGET >> TOL_SHIFT;
    localparam logic [PERIOD_W:0] LO = (PERIOD_W+1)'(TARGET - TOL);
    localparam logic [PERIOD_W:0] HI = (PERIOD_W+1)'(TARGET + TOL);

    assign match[gi] = ({1'b0, period} >= LO) && ({1'b0, period} <= HI);
  end

  // Windows are disjoint, so at most one bit of match is set; the
  // descending scan is only a cheap encoder.
  always_comb begin
    hit   = 1'b0;
    index = '0;
    for (int k = NUM_NOTES - 1; k >= 0; k--) begin
      if (match[k]) begin
        hit   = 1'b1;
        index = note_t'(k);
      end
    end
  end

endmodule

// File: rtl/tone_detector.sv
// tone_detector: recovers which of the 12 keyboard keys produced a square tone.
//   CLK     (in)  1   system clock, 100 MHz.
//   RST     (in)  1   synchronous, active-high reset.
//   tone_in (in)  1   asynchronous square-wave tone.
//   button  (out) 12  one-hot detected key, all zero when not valid.
//   note    (out) 4   detected key index 0..11, 0 when not valid.
//   valid   (out) 1   high while locked on a key.
// The tone is synchronised, its rising-edge period measured, classified
// against the key table, and the result reported after MATCH_CNT
// consecutive periods agree. TIMEOUT_CYC cycles without an edge means
// silence.
// Build option TONE_DET_HYST_EN: when defined, a locked detector tolerates
// one isolated non-matching period (held in miss_reg) and drops lock only
// on the second consecutive one.
module tone_detector
  import tone_pkg::*;
#(
  parameter int PERIOD_W     = 20,
  parameter int MATCH_CNT    = 3,
  parameter int TOL_SHIFT    = 6,
  parameter int TIMEOUT_CYC  = 1000000,
  parameter int PERIOD_SHIFT = 0
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 tone_in,
  output logic [NUM_NOTES-1:0] button,
  output note_t                note,
  output logic                 valid
);

  localparam logic [PERIOD_W-1:0] TIMEOUT_V = PERIOD_W'(TIMEOUT_CYC);
  localparam logic [PERIOD_W-1:0] CNT_ONE   = PERIOD_W'(1);
  localparam logic [2:0]          MATCH_V   = 3'(MATCH_CNT);

  logic                 sync1_reg, sync2_reg, prev_reg;
  logic [PERIOD_W-1:0]  cnt_reg;
  state_t               state_reg;
  note_t                cand_reg;
  logic [2:0]           mcnt_reg;
  logic                 valid_reg;
  note_t                note_reg;
  logic [NUM_NOTES-1:0] button_reg;
`ifdef TONE_DET_HYST_EN
  logic                 miss_reg;
`endif

  logic       rise;
  logic       timeout;
  logic       cls_hit;
  note_t      cls_idx;
  logic [2:0] acq_mcnt;
  logic       acq_lock;
  logic       lock_match;
  logic       drop_lock;

  assign rise    = sync2_reg & ~prev_reg;
  assign timeout = (cnt_reg == TIMEOUT_V);

  // cnt_reg holds the period only in the cycle rise is high; the
  // classifier output is ignored in every other cycle.
  period_classifier #(
    .PERIOD_W     (PERIOD_W),
    .TOL_SHIFT    (TOL_SHIFT),
    .PERIOD_SHIFT (PERIOD_SHIFT)
  ) u_classifier (
    .period (cnt_reg),
    .hit    (cls_hit),
    .index  (cls_idx)
  );

  // Agreement count after this period: a miss clears it, a new note
  // restarts it at 1, a repeat of the candidate extends the run.
  always_comb begin
    acq_mcnt = 3'd0;
    if (cls_hit) begin
      if ((cls_idx == cand_reg) && (mcnt_reg != 3'd0)) begin
        acq_mcnt = mcnt_reg + 3'd1;
      end else begin
        acq_mcnt = 3'd1;
      end
    end
  end

  assign acq_lock   = (acq_mcnt == MATCH_V);
  assign lock_match = cls_hit && (cls_idx == note_reg);

`ifdef TONE_DET_HYST_EN
  assign drop_lock = !lock_match && miss_reg;
`else
  assign drop_lock = !lock_match;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1_reg  <= 1'b0;
      sync2_reg  <= 1'b0;
      prev_reg   <= 1'b0;
      cnt_reg    <= '0;
      state_reg  <= SILENT;
      cand_reg   <= '0;
      mcnt_reg   <= 3'd0;
      valid_reg  <= 1'b0;
      note_reg   <= '0;
      button_reg <= '0;
`ifdef TONE_DET_HYST_EN
      miss_reg   <= 1'b0;
`endif
    end else begin
      sync1_reg <= tone_in;
      sync2_reg <= sync1_reg;
      prev_reg  <= sync2_reg;

      // Counting restarts at 1 so the value seen on the next edge is the
      // exact cycle distance between the two edges.
      if (rise) begin
        cnt_reg <= CNT_ONE;
      end else if (!timeout) begin
        cnt_reg <= cnt_reg + CNT_ONE;
      end

      // An edge takes precedence over a timeout in the same cycle.
      if (rise) begin
        case (state_reg)
          SILENT: begin
            // No previous edge, so the counter holds no period yet.
            state_reg <= ACQUIRE;
            mcnt_reg  <= 3'd0;
          end
          ACQUIRE: begin
            mcnt_reg <= acq_mcnt;
            if (cls_hit) begin
              cand_reg <= cls_idx;
            end
            if (acq_lock) begin
              state_reg  <= LOCKED;
              valid_reg  <= 1'b1;
              note_reg   <= cls_idx;
              button_reg <= note_onehot(cls_idx);
`ifdef TONE_DET_HYST_EN
              miss_reg   <= 1'b0;
`endif
            end
          end
          LOCKED: begin
`ifdef TONE_DET_HYST_EN
            // First stray period only arms the flag; a match disarms it.
            miss_reg <= !lock_match && !miss_reg;
`endif
            if (drop_lock) begin
              // The dropping period seeds the next acquisition.
              state_reg  <= ACQUIRE;
              valid_reg  <= 1'b0;
              note_reg   <= '0;
              button_reg <= '0;
              mcnt_reg   <= cls_hit ? 3'd1 : 3'd0;
              if (cls_hit) begin
                cand_reg <= cls_idx;
              end
            end
          end
          default: begin
            state_reg <= SILENT;
          end
        endcase
      end else if (timeout) begin
        state_reg  <= SILENT;
        mcnt_reg   <= 3'd0;
        valid_reg  <= 1'b0;
        note_reg   <= '0;
        button_reg <= '0;
`ifdef TONE_DET_HYST_EN
        miss_reg   <= 1'b0;
`endif
      end
    end
  end

  assign valid  = valid_reg;
  assign note   = note_reg;
  assign button = button_reg;

endmodule

// File: tb/tb_tone_detector.sv
// tb_tone_detector: directed bench for tone_detector.
// The key table is scaled down by 2^8 (A4 = 887 cycles, tolerance 13) and
// the silence timeout shortened to 3000 cycles so the run stays short.
// Stimulus pushes each expected output change (cycle + value) into a
// queue; the monitor pops and compares when an entry falls due and flags
// any output change nobody announced.
`timescale 1ns/1ps
module tb_tone_detector;

  localparam int T_TIMEOUT = 3000;
  localparam int P_A4      = 887;
  localparam int P_C4      = 1493;
  localparam int P_MISS    = 1600;
  // A tone_in rise driven at cycle c is seen on the outputs at c + 3.
  localparam int LAT       = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        tone_in;
  logic [11:0] button;
  logic [3:0]  note;
  logic        valid;

  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tone_detector #(
    .PERIOD_W     (20),
    .MATCH_CNT    (3),
    .TOL_SHIFT    (6),
    .TIMEOUT_CYC  (T_TIMEOUT),
    .PERIOD_SHIFT (8)
  ) dut (
    .CLK     (clk),
    .RST     (rst),
    .tone_in (tone_in),
    .button  (button),
    .note    (note),
    .valid   (valid)
  );

  typedef struct {
    int          cyc;
    logic        v;
    logic [3:0]  n;
    logic [11:0] b;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    check_cnt = 0;
  int    pass_cnt  = 0;
  bit    mon_en    = 1'b0;
  int    last_edge_cyc = 0;

  // Boundary table: A4 window is 874..900, C4 window 1470..1516.
  int          tv_period [8] = '{900, 874, 901, 873, 790, 1409, 1516, 1517};
  bit          tv_lock   [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [3:0]  tv_note   [8] = '{4'd9, 4'd9, 4'd0, 4'd0, 4'd11, 4'd1, 4'd0, 4'd0};
  logic [11:0] tv_button [8] = '{12'h200, 12'h200, 12'h000, 12'h000,
                                 12'h800, 12'h002, 12'h001, 12'h000};

  task automatic expect_at(input int due, input logic v, input logic [3:0] n,
                           input logic [11:0] b, input string nm);
    exp_t e;
    e.cyc = due;
    e.v   = v;
    e.n   = n;
    e.b   = b;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Called at a negedge with tone_in low.
  task automatic first_edge();
    tone_in = 1'b1;
    last_edge_cyc = cyc;
  endtask

  // Next rising edge exactly p cycles after the previous one.
  task automatic period_edge(input int p, input bit push, input logic v,
                             input logic [3:0] n, input logic [11:0] b,
                             input string nm);
    repeat (p / 2) @(negedge clk);
    tone_in = 1'b0;
    repeat (p - p / 2) @(negedge clk);
    tone_in = 1'b1;
    last_edge_cyc = cyc;
    if (push) expect_at(cyc + LAT, v, n, b, nm);
  endtask

  task automatic plain_edge(input int p);
    period_edge(p, 1'b0, 1'b0, 4'd0, 12'h000, "");
  endtask

  task automatic quiet(input int n);
    repeat (8) @(negedge clk);
    tone_in = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_rst(input bit was_locked, input string nm);
    rst = 1'b1;
    if (was_locked) expect_at(cyc + 1, 1'b0, 4'd0, 12'h000, nm);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin : monitor
    exp_t        e;
    string       nm;
    logic [16:0] cur, prev, want;
    wait (mon_en);
    prev = {valid, note, button};
    forever begin
      @(negedge clk);
      cur = {valid, note, button};
      if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        e    = exp_q.pop_front();
        nm   = name_q.pop_front();
        want = {e.v, e.n, e.b};
        check_cnt++;
        if (e.cyc == cyc && cur === want) begin
          pass_cnt++;
          $display("ok   %s cyc=%0d valid=%0b note=%0d button=%03h",
                   nm, cyc, cur[16], cur[15:12], cur[11:0]);
        end else begin
          $display("FAIL %s: got cyc=%0d valid=%0b note=%0d button=%03h, want cyc=%0d valid=%0b note=%0d button=%03h",
                   nm, cyc, cur[16], cur[15:12], cur[11:0],
                   e.cyc, want[16], want[15:12], want[11:0]);
        end
      end else if (cur !== prev) begin
        check_cnt++;
        $display("FAIL unexpected_change: cyc=%0d got valid=%0b note=%0d button=%03h, want unchanged valid=%0b note=%0d button=%03h",
                 cyc, cur[16], cur[15:12], cur[11:0],
                 prev[16], prev[15:12], prev[11:0]);
      end
      prev = cur;
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got no end of stimulus by cyc=%0d, want finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    rst     = 1'b1;
    tone_in = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    expect_at(cyc + 1, 1'b0, 4'd0, 12'h000, "reset_state");
    mon_en = 1'b1;

    // A4 lock on the 4th rising edge, then hold while it continues.
    first_edge();
    plain_edge(P_A4);
    plain_edge(P_A4);
    period_edge(P_A4, 1'b1, 1'b1, 4'd9, 12'h200, "a4_lock");
    plain_edge(P_A4);
    plain_edge(P_A4);

    // Switch to C4.
`ifdef TONE_DET_HYST_EN
    plain_edge(P_C4);
    period_edge(P_C4, 1'b1, 1'b0, 4'd0, 12'h000, "c4_switch_drop");
    plain_edge(P_C4);
    period_edge(P_C4, 1'b1, 1'b1, 4'd0, 12'h001, "c4_relock");
`else
    period_edge(P_C4, 1'b1, 1'b0, 4'd0, 12'h000, "c4_switch_drop");
    plain_edge(P_C4);
    period_edge(P_C4, 1'b1, 1'b1, 4'd0, 12'h001, "c4_relock");
`endif

    // Silence: outputs clear exactly T_TIMEOUT cycles after the last edge.
    expect_at(last_edge_cyc + LAT + T_TIMEOUT, 1'b0, 4'd0, 12'h000, "timeout_drop");
    quiet(T_TIMEOUT + 20);

    // Tolerance boundaries and other keys; each starts from silence/reset.
    for (int i = 0; i < 8; i++) begin
      first_edge();
      for (int j = 0; j < (tv_lock[i] ? 3 : 4); j++) begin
        period_edge(tv_period[i], tv_lock[i] && (j == 2), 1'b1, tv_note[i],
                    tv_button[i], $sformatf("lock_p%0d", tv_period[i]));
      end
      quiet(10);
      pulse_rst(tv_lock[i], $sformatf("rst_clear_p%0d", tv_period[i]));
    end

    // A miss during acquisition restarts the agreement run.
    first_edge();
    plain_edge(P_A4);
    plain_edge(P_A4);
    plain_edge(P_MISS);
    plain_edge(P_A4);
    plain_edge(P_A4);
    period_edge(P_A4, 1'b1, 1'b1, 4'd9, 12'h200, "acq_miss_relock");

    // Stray periods while locked.
`ifdef TONE_DET_HYST_EN
    plain_edge(P_MISS);
    plain_edge(P_A4);
    plain_edge(P_MISS);
    period_edge(P_MISS, 1'b1, 1'b0, 4'd0, 12'h000, "second_miss_drop");
`else
    period_edge(P_MISS, 1'b1, 1'b0, 4'd0, 12'h000, "single_miss_drop");
`endif
    plain_edge(P_A4);
    plain_edge(P_A4);
    period_edge(P_A4, 1'b1, 1'b1, 4'd9, 12'h200, "relock_after_miss");
    quiet(10);
    pulse_rst(1'b1, "rst_final");

    repeat (20) @(negedge clk);
    check_cnt++;
    if (exp_q.size() == 0) begin
      pass_cnt++;
    end else begin
      $display("FAIL pending_expectations: got %0d unserved, want 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
